rgb_cmd_ctrl: RTL and testbench

Synchronous command controller between the UART receiver, the UART transmitter and the RGB PWM channel registers. It parses framed ASCII commands from `serial_rx` and writes the 7-bit duty values for the green, red and blue PWM channels. It sequences one-byte replies through `serial_tx` using that block's send/busy handshake. All state lives in the `clock` domain, and there are no negedge or asynchronously clocked registers.

---
 rtl/rgb_cmd_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rgb_cmd_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_cmd_ctrl.sv
// Command controller: parses framed ASCII set/query commands from the UART receiver,
// updates the RGB PWM duty registers and sequences one-byte replies to the transmitter.
module rgb_cmd_ctrl #(
    parameter logic [6:0]  RESET_G        = 7'h3E,
    parameter logic [6:0]  RESET_R        = 7'h1E,
    parameter logic [6:0]  RESET_B        = 7'h7E,
    parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic [6:0] ch_green,
    output logic [6:0] ch_red,
    output logic [6:0] ch_blue,
    output logic [1:0] sel_color,
    output logic       err
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     CHR_E    = 8'h45;
    localparam logic [7:0]     CHR_K    = 8'h4B;

    typedef enum logic [2:0] {
        IDLE,
        HEX_HI,
        HEX_LO,
        SEND,
        DRAIN
    } state_t;

    state_t           state, state_d;
    logic             rx_q;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       hi, hi_d;
    logic [7:0]       tx_byte_d;
    logic             tx_send_d, err_d;
    logic [6:0]       ch_green_d, ch_red_d, ch_blue_d;
    logic [1:0]       sel_d;
    logic             consume;
    logic [4:0]       digit;
    logic [7:0]       value;
    logic [6:0]       cur_ch;
    logic             reply_err;

    // Returns {valid, nibble} for an ASCII hex digit
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      return {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        else                               return 5'b0;
    endfunction

    assign consume = rx_ready & ~rx_q;
    assign digit   = hex_decode(rx_byte);
    assign value   = {hi, digit[3:0]};

    always_comb begin
        case (sel_color)
            2'd1:    cur_ch = ch_red;
            2'd2:    cur_ch = ch_blue;
            default: cur_ch = ch_green;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        hi_d       = hi;
        tx_byte_d  = tx_byte;
        tx_send_d  = tx_send;
        err_d      = 1'b0;
        ch_green_d = ch_green;
        ch_red_d   = ch_red;
        ch_blue_d  = ch_blue;
        sel_d      = sel_color;
        reply_err  = 1'b0;

        case (state)
            IDLE: begin
                if (consume) begin
                    case (rx_byte)
                        8'h67: begin sel_d = 2'd0; cnt_d = '0; state_d = HEX_HI; end
                        8'h72: begin sel_d = 2'd1; cnt_d = '0; state_d = HEX_HI; end
                        8'h62: begin sel_d = 2'd2; cnt_d = '0; state_d = HEX_HI; end
                        8'h3F: begin
                            tx_byte_d = {1'b1, cur_ch};
                            tx_send_d = 1'b1;
                            state_d   = SEND;
                        end
                        8'h0D, 8'h0A: ;
                        default: reply_err = 1'b1;
                    endcase
                end
            end
            HEX_HI, HEX_LO: begin
                if (consume) begin
                    cnt_d = '0;
                    if (!digit[4]) begin
                        reply_err = 1'b1;
                    end else if (state == HEX_HI) begin
                        hi_d    = digit[3:0];
                        state_d = HEX_LO;
                    end else if (value[7]) begin
                        reply_err = 1'b1;
                    end else begin
                        case (sel_color)
                            2'd1:    ch_red_d   = value[6:0];
                            2'd2:    ch_blue_d  = value[6:0];
                            default: ch_green_d = value[6:0];
                        endcase
                        tx_byte_d = CHR_K;
                        tx_send_d = 1'b1;
                        state_d   = SEND;
                    end
                end else if (cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            SEND: begin
                if (tx_busy) begin
                    tx_send_d = 1'b0;
                    state_d   = DRAIN;
                end
                if (consume) err_d = 1'b1;
            end
            DRAIN: begin
                if (!tx_busy) state_d = IDLE;
                if (consume) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (reply_err) begin
            tx_byte_d = CHR_E;
            tx_send_d = 1'b1;
            err_d     = 1'b1;
            state_d   = SEND;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rx_q      <= 1'b0;
            cnt       <= '0;
            hi        <= 4'h0;
            tx_byte   <= 8'h00;
            tx_send   <= 1'b0;
            err       <= 1'b0;
            ch_green  <= RESET_G;
            ch_red    <= RESET_R;
            ch_blue   <= RESET_B;
            sel_color <= 2'd0;
        end else begin
            state     <= state_d;
            rx_q      <= rx_ready;
            cnt       <= cnt_d;
            hi        <= hi_d;
            tx_byte   <= tx_byte_d;
            tx_send   <= tx_send_d;
            err       <= err_d;
            ch_green  <= ch_green_d;
            ch_red    <= ch_red_d;
            ch_blue   <= ch_blue_d;
            sel_color <= sel_d;
        end
    end

endmodule

// File: tb/tb_rgb_cmd_ctrl.sv
// Bench for rgb_cmd_ctrl: table of command frames with hand-computed replies and duty
// values, plus directed sequences for timeout, overlap during send and mid-frame reset.
module tb_rgb_cmd_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic [7:0] tx_byte;
    logic       tx_send;
    logic       tx_busy;
    logic [6:0] ch_green, ch_red, ch_blue;
    logic [1:0] sel_color;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int reply_cnt = 0;
    logic [7:0] last_reply = 8'h00;
    int busy_len = 100;
    int busy_delay = 0;

    rgb_cmd_ctrl #(
        .RESET_G(7'h3E), .RESET_R(7'h1E), .RESET_B(7'h7E), .TIMEOUT_CYCLES(50)
    ) dut (
        .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .tx_byte(tx_byte), .tx_send(tx_send), .tx_busy(tx_busy),
        .ch_green(ch_green), .ch_red(ch_red), .ch_blue(ch_blue),
        .sel_color(sel_color), .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (err) err_cnt <= err_cnt + 1;

    // serial_tx model: accepts a send request, goes busy for busy_len cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (tx_send && !tx_busy && !reset) begin
                reply_cnt  = reply_cnt + 1;
                last_reply = tx_byte;
                repeat (busy_delay) begin @(posedge clock); #1; end
                tx_busy = 1'b1;
                repeat (busy_len) @(posedge clock);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Idle one edge so rx_q clears, then present the byte for exactly one consuming edge
    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        rx_byte  = b;
        rx_ready = 1'b1;
        @(posedge clock); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 1000; k++) begin
            if (!tx_busy && !tx_send) break;
            @(posedge clock); #1;
        end
        check("reply_done_bound", 32'(k < 1000), 32'd1);
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] exp_reply;
        logic       exp_err;
        logic [6:0] exp_g, exp_r, exp_b;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int e0, r0;
        logic [7:0] bytes[3];

        vecs[0]  = '{8'h72, 8'h34, 8'h41, 3, 8'h4B, 1'b0, 7'h3E, 7'h4A, 7'h7E, 2'd1};
        vecs[1]  = '{8'h3F, 8'h00, 8'h00, 1, 8'hCA, 1'b0, 7'h3E, 7'h4A, 7'h7E, 2'd1};
        vecs[2]  = '{8'h67, 8'h38, 8'h30, 3, 8'h45, 1'b1, 7'h3E, 7'h4A, 7'h7E, 2'd0};
        vecs[3]  = '{8'h62, 8'h5A, 8'h00, 2, 8'h45, 1'b1, 7'h3E, 7'h4A, 7'h7E, 2'd2};
        vecs[4]  = '{8'h78, 8'h00, 8'h00, 1, 8'h45, 1'b1, 7'h3E, 7'h4A, 7'h7E, 2'd2};
        vecs[5]  = '{8'h62, 8'h30, 8'h66, 3, 8'h4B, 1'b0, 7'h3E, 7'h4A, 7'h0F, 2'd2};
        vecs[6]  = '{8'h3F, 8'h00, 8'h00, 1, 8'h8F, 1'b0, 7'h3E, 7'h4A, 7'h0F, 2'd2};
        vecs[7]  = '{8'h67, 8'h46, 8'h46, 3, 8'h45, 1'b1, 7'h3E, 7'h4A, 7'h0F, 2'd0};
        vecs[8]  = '{8'h67, 8'h37, 8'h66, 3, 8'h4B, 1'b0, 7'h7F, 7'h4A, 7'h0F, 2'd0};
        vecs[9]  = '{8'h3F, 8'h00, 8'h00, 1, 8'hFF, 1'b0, 7'h7F, 7'h4A, 7'h0F, 2'd0};
        vecs[10] = '{8'h72, 8'h31, 8'h63, 3, 8'h4B, 1'b0, 7'h7F, 7'h1C, 7'h0F, 2'd1};
        vecs[11] = '{8'h0D, 8'h3F, 8'h00, 2, 8'h9C, 1'b0, 7'h7F, 7'h1C, 7'h0F, 2'd1};

        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_byte  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check("rst_green", 32'(ch_green), 32'h3E);
        check("rst_red",   32'(ch_red),   32'h1E);
        check("rst_blue",  32'(ch_blue),  32'h7E);
        check("rst_sel",   32'(sel_color), 32'd0);
        check("rst_send",  32'(tx_send),  32'd0);
        check("rst_err",   32'(err),      32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            e0 = err_cnt;
            r0 = reply_cnt;
            bytes[0] = vecs[i].b0;
            bytes[1] = vecs[i].b1;
            bytes[2] = vecs[i].b2;
            for (int j = 0; j < vecs[i].n; j++) send_byte(bytes[j]);
            check($sformatf("v%0d_send", i),  32'(tx_send),   32'd1);
            check($sformatf("v%0d_byte", i),  32'(tx_byte),   32'(vecs[i].exp_reply));
            check($sformatf("v%0d_err", i),   32'(err),       32'(vecs[i].exp_err));
            check($sformatf("v%0d_green", i), 32'(ch_green),  32'(vecs[i].exp_g));
            check($sformatf("v%0d_red", i),   32'(ch_red),    32'(vecs[i].exp_r));
            check($sformatf("v%0d_blue", i),  32'(ch_blue),   32'(vecs[i].exp_b));
            check($sformatf("v%0d_sel", i),   32'(sel_color), 32'(vecs[i].exp_sel));
            @(posedge clock); #1;
            check($sformatf("v%0d_send_fall", i), 32'(tx_send), 32'd0);
            check($sformatf("v%0d_byte_hold", i), 32'(tx_byte), 32'(vecs[i].exp_reply));
            wait_idle();
            check($sformatf("v%0d_replies", i), 32'(reply_cnt - r0), 32'd1);
            check($sformatf("v%0d_reply", i),   32'(last_reply),     32'(vecs[i].exp_reply));
            check($sformatf("v%0d_errcnt", i),  32'(err_cnt - e0),   32'(vecs[i].exp_err));
        end

        // Timeout inside a frame: no reply, single err pulse, channels untouched
        e0 = err_cnt;
        r0 = reply_cnt;
        send_byte(8'h67);
        send_byte(8'h33);
        repeat (49) begin @(posedge clock); #1; end
        check("to_err_early", 32'(err), 32'd0);
        @(posedge clock); #1;
        check("to_err_fire", 32'(err), 32'd1);
        check("to_no_send",  32'(tx_send), 32'd0);
        @(posedge clock); #1;
        check("to_err_drop", 32'(err), 32'd0);
        check("to_errcnt",   32'(err_cnt - e0), 32'd1);
        check("to_replies",  32'(reply_cnt - r0), 32'd0);
        check("to_green",    32'(ch_green), 32'h7F);
        send_byte(8'h67);
        send_byte(8'h31);
        send_byte(8'h30);
        check("to_set_green", 32'(ch_green), 32'h10);
        check("to_set_reply", 32'(tx_byte),  32'h4B);
        wait_idle();

        // Byte arriving while a reply is still pending is dropped with one err pulse
        busy_delay = 3;
        e0 = err_cnt;
        r0 = reply_cnt;
        send_byte(8'h3F);
        check("ov_query", 32'(tx_byte), 32'h90);
        send_byte(8'h72);
        check("ov_err",  32'(err),       32'd1);
        check("ov_send", 32'(tx_send),   32'd1);
        check("ov_sel",  32'(sel_color), 32'd0);
        wait_idle();
        busy_delay = 0;
        check("ov_errcnt",  32'(err_cnt - e0),   32'd1);
        check("ov_replies", 32'(reply_cnt - r0), 32'd1);
        send_byte(8'h3F);
        check("ov_after", 32'(tx_byte), 32'h90);
        wait_idle();
        check("ov_after_reply", 32'(last_reply), 32'h90);

        // Reset between letter and first digit
        send_byte(8'h62);
        check("mr_sel_pre", 32'(sel_color), 32'd2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mr_blue",  32'(ch_blue),   32'h7E);
        check("mr_green", 32'(ch_green),  32'h3E);
        check("mr_red",   32'(ch_red),    32'h1E);
        check("mr_sel",   32'(sel_color), 32'd0);
        check("mr_send",  32'(tx_send),   32'd0);
        send_byte(8'h35);
        check("mr_idle_reply", 32'(tx_byte), 32'h45);
        check("mr_idle_err",   32'(err),     32'd1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
